// File: rtl/iir_stream_wb.sv
// -----------------------------------------------------------------------------
// iir_stream_wb
//   Wishbone-slave wrapper around an external fixed-latency streaming filter
//   core. Software loads up to DEPTH samples into the X buffer, starts a run,
//   and the block feeds N samples to the core on consecutive cycles. Results
//   are captured FILT_LAT cycles later into the Y buffer, then DONE (and
//   int_o when IE is set) is raised.
//
//   Optional feature macro: IIR_STREAM_CONT_EN
//     defined   : CTRL.CONT restarts a new frame on each completion.
//     undefined : single-shot only, CONT reads 0.
//
//   Ports
//     wb_clk_i   clock for the block and the external core
//     wb_rst_i   asynchronous active-low reset
//     wb_adr_i   byte address, [5:2] selects the register
//     wb_cyc_i / wb_stb_i / wb_we_i / wb_sel_i / wb_dat_i   bus request
//     wb_dat_o   read data, valid with wb_ack_o
//     wb_ack_o   registered acknowledge
//     wb_err_o   registered error (write rejected while busy)
//     int_o      interrupt level, DONE & IE
//     flt_dat_o  sample to the core, 0 when not feeding
//     flt_vld_o  high on cycles carrying a buffered sample
//     flt_dat_i  core output sample
// -----------------------------------------------------------------------------
module iir_stream_wb #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int FILT_LAT = 10
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [31:0]   wb_adr_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [3:0]    wb_sel_i,
  input  logic [31:0]   wb_dat_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          int_o,
  output logic [DW-1:0] flt_dat_o,
  output logic          flt_vld_o,
  input  logic [DW-1:0] flt_dat_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;  // holds N = DEPTH without wrapping

  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_STATUS = 4'd1;
  localparam logic [3:0] REG_LEN    = 4'd2;
  localparam logic [3:0] REG_XADDR  = 4'd3;
  localparam logic [3:0] REG_XDATA  = 4'd4;
  localparam logic [3:0] REG_YADDR  = 4'd5;
  localparam logic [3:0] REG_YDATA  = 4'd6;
  localparam logic [3:0] REG_ID     = 4'd7;

  localparam logic [31:0] ID_WORD = {16'(DEPTH), 8'(DW), 8'(FILT_LAT)};

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   feed_cnt, cap_cnt, len_q;
  logic [AW-1:0]   xaddr_q, yaddr_q;
  logic [FILT_LAT-1:0] vld_sr;
  logic            ie_q, done_q, ovr_q, cont_q;
  logic [DW-1:0]   x_mem [DEPTH];
  logic [DW-1:0]   y_mem [DEPTH];
  logic [31:0]     rdata;

  // Bus decode. A response in flight blocks a new request, which spaces
  // back-to-back requests one response every second cycle.
  logic [3:0] reg_sel;
  logic       busy, req, wr_req, rd_req, reject, wr_ok, start_go;
  logic       cap_vld, frame_done, frame_load;
  logic [CW-1:0] len_m1, len_wr;

  assign reg_sel  = wb_adr_i[5:2];
  assign busy     = (state_q != IDLE);
  assign req      = wb_cyc_i & wb_stb_i & ~(wb_ack_o | wb_err_o);
  assign wr_req   = req & wb_we_i;
  assign rd_req   = req & ~wb_we_i;
  assign reject   = wr_req & busy &
                    (((reg_sel == REG_CTRL) & wb_dat_i[0]) | (reg_sel == REG_LEN) |
                     (reg_sel == REG_XADDR) | (reg_sel == REG_XDATA));
  assign wr_ok    = wr_req & ~reject;
  assign start_go = wr_ok & (reg_sel == REG_CTRL) & wb_dat_i[0];

  assign len_m1     = len_q - CW'(1);
  assign len_wr     = wb_dat_i[CW-1:0];
  assign cap_vld    = vld_sr[FILT_LAT-1];
  assign frame_done = (state_q == DRAIN) & cap_vld & (cap_cnt == len_m1);
  // Counters restart whenever a frame begins, from IDLE or a CONT restart.
  assign frame_load = (state_d == FEED) & (state_q != FEED);

  assign flt_vld_o = (state_q == FEED);
  assign flt_dat_o = flt_vld_o ? x_mem[feed_cnt[AW-1:0]] : '0;
  assign int_o     = done_q & ie_q;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_go) state_d = FEED;
      FEED:    if (feed_cnt == len_m1) state_d = DRAIN;
      DRAIN:   if (frame_done) state_d = cont_q ? FEED : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL:   rdata = {29'd0, cont_q, ie_q, 1'b0};
      REG_STATUS: rdata = {29'd0, ovr_q, done_q, busy};
      REG_LEN:    rdata = 32'(len_q);
      REG_XADDR:  rdata = 32'(xaddr_q);
      REG_YADDR:  rdata = 32'(yaddr_q);
      REG_YDATA:  rdata = 32'(y_mem[yaddr_q]);
      REG_ID:     rdata = ID_WORD;
      default:    rdata = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q  <= IDLE;
      feed_cnt <= '0;
      cap_cnt  <= '0;
      vld_sr   <= '0;
    end else begin
      state_q <= state_d;
      if (frame_load)            feed_cnt <= '0;
      else if (state_q == FEED)  feed_cnt <= feed_cnt + CW'(1);
      if (frame_load)            cap_cnt <= '0;
      else if (cap_vld)          cap_cnt <= cap_cnt + CW'(1);
      // Valid delayed by the core latency marks which core outputs to keep.
      vld_sr[0] <= flt_vld_o;
      for (int i = 1; i < FILT_LAT; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      ie_q     <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      len_q    <= CW'(DEPTH);  // a cleared LEN means "full buffer"
      xaddr_q  <= '0;
      yaddr_q  <= '0;
`ifdef IIR_STREAM_CONT_EN
      cont_q   <= 1'b0;
`endif
    end else begin
      wb_ack_o <= req & ~reject;
      wb_err_o <= reject;
      wb_dat_o <= rd_req ? rdata : '0;

      if (wr_ok && reg_sel == REG_CTRL) begin
        ie_q <= wb_dat_i[1];
`ifdef IIR_STREAM_CONT_EN
        cont_q <= wb_dat_i[2];
`endif
      end

      // Completion outranks any clear issued in the same cycle.
      if (frame_done)                                          done_q <= 1'b1;
      else if (start_go)                                       done_q <= 1'b0;
      else if (wr_ok && reg_sel == REG_STATUS && wb_dat_i[1])  done_q <= 1'b0;

      if (reject)                                              ovr_q <= 1'b1;
      else if (wr_ok && reg_sel == REG_STATUS && wb_dat_i[2])  ovr_q <= 1'b0;

      if (wr_ok && reg_sel == REG_LEN)
        len_q <= (len_wr == '0 || len_wr > CW'(DEPTH)) ? CW'(DEPTH) : len_wr;

      if (wr_ok && reg_sel == REG_XADDR)      xaddr_q <= wb_dat_i[AW-1:0];
      else if (wr_ok && reg_sel == REG_XDATA) xaddr_q <= xaddr_q + AW'(1);

      if (wr_ok && reg_sel == REG_YADDR)       yaddr_q <= wb_dat_i[AW-1:0];
      else if (rd_req && reg_sel == REG_YDATA) yaddr_q <= yaddr_q + AW'(1);
    end
  end

`ifndef IIR_STREAM_CONT_EN
  assign cont_q = 1'b0;
`endif

  // NOTE: buffer RAMs carry no reset so they map onto plain memory; their
  // contents survive a reset and are only meaningful once written.
  always_ff @(posedge wb_clk_i) begin
    if (wr_ok && reg_sel == REG_XDATA) x_mem[xaddr_q] <= wb_dat_i[DW-1:0];
    if (cap_vld)                       y_mem[cap_cnt[AW-1:0]] <= flt_dat_i;
  end

  logic unused_bits;
  assign unused_bits = ^{wb_sel_i, wb_adr_i, wb_dat_i};

endmodule
